// File: rtl/biu_pkg.sv
// Shared definitions for the EX-stage bus interface port.
// Contents: FSM state encoding, one-hot access-size codes and a helper
// that turns a size code into an 8-bit byte-lane mask.
package biu_pkg;

  // Transaction sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHK   = 3'd1,
    ST_BUS   = 3'd2,
    ST_RDY   = 3'd3,
    ST_DATA  = 3'd4,
    ST_DRAIN = 3'd5
  } state_t;

  // One-hot access size codes as driven by EX.
  localparam logic [3:0] SZ_B = 4'b0001;
  localparam logic [3:0] SZ_H = 4'b0010;
  localparam logic [3:0] SZ_W = 4'b0100;
  localparam logic [3:0] SZ_D = 4'b1000;

  // Byte-lane mask for an access of the given size, anchored at lane 0.
  // A non-one-hot code yields an empty mask; such accesses never reach the bus.
  function automatic logic [7:0] size_mask(input logic [3:0] size);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      SZ_D:    m = 8'hFF;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/biu_lane_align.sv
// Combinational byte-lane steering for one 64-bit bus beat.
// Ports: addr_lo/size/wdata describe the access; rdata is the raw bus beat;
// bsel/wdata_lane/rdata_aligned are the steered results; illegal flags a bad size or misalignment.
module biu_lane_align
  import biu_pkg::*;
(
  input  logic [2:0]  addr_lo,
  input  logic [3:0]  size,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [7:0]  bsel,
  output logic [63:0] wdata_lane,
  output logic [63:0] rdata_aligned,
  output logic        illegal
);

  logic [7:0]  mask;
  logic [5:0]  bit_off;
  logic [63:0] rshift;
  logic [63:0] rmask;

  always_comb begin
    mask    = size_mask(size);
    bit_off = {addr_lo, 3'b000};

    // Legal accesses never straddle the beat, so the 8-bit shift cannot lose lanes.
    bsel       = mask << addr_lo;
    wdata_lane = wdata << bit_off;

    // Loads come back right-justified and zero-extended; EX sign-extends.
    rshift = rdata >> bit_off;
    rmask  = '0;
    for (int i = 0; i < 8; i++) begin
      rmask[i*8 +: 8] = {8{mask[i]}};
    end
    rdata_aligned = rshift & rmask;

    // Natural alignment required; any non-one-hot size is illegal outright.
    case (size)
      SZ_B:    illegal = 1'b0;
      SZ_H:    illegal = addr_lo[0];
      SZ_W:    illegal = |addr_lo[1:0];
      SZ_D:    illegal = |addr_lo;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_biu_port.sv
// EX-stage memory port: turns a held read/write request into one aligned, byte-laned req/ack bus beat.
// Ports: EX side (read/write/addr_ex/size_biu/data_write in; ready, data and fault pulses out),
// bus side (bus_req/we/addr/wdata/bsel out; bus_ack/rdata/err in). Optional macro BIU_UNCACHE_REGION_EN enables the uncacheable-region path.
module ex_biu_port
  import biu_pkg::*;
#(
  parameter logic [63:0] UNC_BASE = 64'h0000_0000_1000_0000,
  parameter logic [63:0] UNC_MASK = 64'hFFFF_FFFF_F000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic        write,
  input  logic [63:0] addr_ex,
  input  logic [63:0] data_write,
  input  logic [3:0]  size_biu,
  input  logic        unpage,
  input  logic [3:0]  ex_priv,
  output logic [63:0] data_read,
  output logic        cache_ready_ex,
  output logic [63:0] uncache_data,
  output logic        uncache_data_ready,
  output logic        load_acc_fault,
  output logic        store_acc_fault,
  output logic        load_page_fault,
  output logic        store_page_fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic [7:0]  bus_bsel,
  input  logic        bus_ack,
  input  logic [63:0] bus_rdata,
  input  logic        bus_err
);

  state_t      state;

  // Request captured in IDLE; EX inputs are ignored until we return there.
  logic [63:0] addr_q;
  logic [3:0]  size_q;
  logic [63:0] wdata_q;
  logic        we_q;

  // Aligned load result captured on bus_ack, presented a cycle after cache_ready_ex.
  logic [63:0] load_q;

  logic [63:0] unc_data_q;
  logic        unc_rdy_q;
  logic        unc_hit;

  logic [7:0]  lane_bsel;
  logic [63:0] lane_wdata;
  logic [63:0] lane_rdata;
  logic        lane_illegal;
  logic        unused_trace;

  biu_lane_align u_lane (
    .addr_lo       (addr_q[2:0]),
    .size          (size_q),
    .wdata         (wdata_q),
    .rdata         (bus_rdata),
    .bsel          (lane_bsel),
    .wdata_lane    (lane_wdata),
    .rdata_aligned (lane_rdata),
    .illegal       (lane_illegal)
  );

`ifdef BIU_UNCACHE_REGION_EN
  assign unc_hit            = ((addr_q & UNC_MASK) == (UNC_BASE & UNC_MASK));
  assign uncache_data       = unc_data_q;
  assign uncache_data_ready = unc_rdy_q;
  // unpage and ex_priv are trace-only: they must not influence behaviour.
  assign unused_trace       = ^{unpage, ex_priv};
`else
  // Without the region decode every access is cacheable and the uncache outputs are dead.
  assign unc_hit            = 1'b0;
  assign uncache_data       = '0;
  assign uncache_data_ready = 1'b0;
  assign unused_trace       = ^{unpage, ex_priv, UNC_BASE, UNC_MASK, unc_data_q, unc_rdy_q};
`endif

  // No address translation happens here.
  assign load_page_fault  = 1'b0;
  assign store_page_fault = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= ST_IDLE;
      addr_q          <= '0;
      size_q          <= '0;
      wdata_q         <= '0;
      we_q            <= 1'b0;
      load_q          <= '0;
      unc_data_q      <= '0;
      unc_rdy_q       <= 1'b0;
      data_read       <= '0;
      cache_ready_ex  <= 1'b0;
      load_acc_fault  <= 1'b0;
      store_acc_fault <= 1'b0;
      bus_req         <= 1'b0;
      bus_we          <= 1'b0;
      bus_addr        <= '0;
      bus_wdata       <= '0;
      bus_bsel        <= '0;
    end else begin
      // Completion and fault outputs are single-cycle pulses by default.
      cache_ready_ex  <= 1'b0;
      load_acc_fault  <= 1'b0;
      store_acc_fault <= 1'b0;
      unc_rdy_q       <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (read || write) begin
            addr_q  <= addr_ex;
            size_q  <= size_biu;
            wdata_q <= data_write;
            we_q    <= write;        // store wins when both are raised
            state   <= ST_CHK;
          end
        end

        ST_CHK: begin
          if (lane_illegal) begin
            if (we_q) store_acc_fault <= 1'b1;
            else      load_acc_fault  <= 1'b1;
            state <= ST_DRAIN;
          end else begin
            bus_req   <= 1'b1;
            bus_we    <= we_q;
            bus_addr  <= {addr_q[63:3], 3'b000};
            bus_wdata <= lane_wdata;
            bus_bsel  <= lane_bsel;
            state     <= ST_BUS;
          end
        end

        ST_BUS: begin
          // Beat registers stay frozen until the slave acknowledges.
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (bus_err) begin
              if (we_q) store_acc_fault <= 1'b1;
              else      load_acc_fault  <= 1'b1;
              state <= ST_DRAIN;
            end else if (unc_hit) begin
              unc_rdy_q <= 1'b1;
              if (!we_q) unc_data_q <= lane_rdata;
              state <= ST_DRAIN;
            end else begin
              cache_ready_ex <= 1'b1;
              load_q         <= lane_rdata;
              state          <= ST_RDY;
            end
          end
        end

        ST_RDY: begin
          // Stores leave data_read untouched so the last load value survives.
          if (!we_q) data_read <= load_q;
          state <= ST_DATA;
        end

        ST_DATA: begin
          state <= ST_DRAIN;
        end

        ST_DRAIN: begin
          // Wait for EX to drop the request so a held request is not replayed.
          if (!read && !write) state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ex_biu_port.md
# ex_biu_port

Responder end of the EX-stage memory interface: it accepts single load/store requests driven by the execute unit (`read`/`write`, `addr_ex`, `size_biu`, `data_write`) and completes them with `cache_ready_ex`/`data_read`, `uncache_data_ready`/`uncache_data` or a fault pulse. It sits between EX and the system bus. Each request becomes one 64-bit-aligned, byte-laned req/ack transaction. It performs lane alignment, size legality checks and cacheable/uncacheable region decode.

## Interface
Parameters:
- `UNC_BASE`, 64'h0000_0000_1000_0000, base of the uncacheable region.
- `UNC_MASK`, 64'hFFFF_FFFF_F000_0000, address bits compared against `UNC_BASE`.

Ports:
- `clk`  in  1  sole clock. All logic is on the rising edge.
- `rst`  in  1  synchronous reset, active-low.
- `read`  in  1  load request from EX. Held until completion.
- `write`  in  1  store request from EX. Held until completion.
- `addr_ex`  in  64  byte address.
- `data_write`  in  64  store data, right-justified.
- `size_biu`  in  4  access size: 0001=1B, 0010=2B, 0100=4B, 1000=8B. Any other value is illegal.
- `unpage`  in  1  physical-only flag. Carried for trace only; it does not change behaviour.
- `ex_priv`  in  4  privilege level. Carried for trace only; it does not change behaviour.
- `data_read`  out  64  cacheable load data, right-justified and zero-extended.
- `cache_ready_ex`  out  1  cacheable completion. Asserted one cycle before `data_read` is valid.
- `uncache_data`  out  64  uncacheable load data, right-justified and zero-extended.
- `uncache_data_ready`  out  1  uncacheable completion. Asserted in the same cycle as `uncache_data`.
- `load_acc_fault`, `store_acc_fault`  out  1  one-cycle fault pulses.
- `load_page_fault`, `store_page_fault`  out  1  tied 0. This block does no translation.
- `bus_req`  out  1  bus request. Held until `bus_ack`.
- `bus_we`  out  1  bus write enable.
- `bus_addr`  out  64  bus address. Low 3 bits are forced to 0.
- `bus_wdata`  out  64  write data, shifted into its byte lanes.
- `bus_bsel`  out  8  byte-lane selects.
- `bus_ack`  in  1  transaction complete.
- `bus_rdata`  in  64  read data. Valid when `bus_ack`=1.
- `bus_err`  in  1  error response. Sampled when `bus_ack`=1.

## Operation
- States: IDLE, CHK, BUS, RDY, DATA, DRAIN.
- IDLE:
  - If `read|write`, latch the address, size, data and direction, then go to CHK.
  - `write` has priority when both are high.
- CHK: if the access is illegal, pulse the matching `*_acc_fault` and go to DRAIN; no bus cycle is issued. An access is illegal when either:
  - `size_biu` is not one-hot, or
  - it is misaligned: 2B with `addr[0]`≠0, 4B with `addr[1:0]`≠0, or 8B with `addr[2:0]`≠0.
- CHK, legal access: assert `bus_req` and go to BUS.
- Lane rules:
  - `bus_bsel` = size mask shifted left by `addr[2:0]`.
  - `bus_wdata` = `data_write` shifted left by 8·`addr[2:0]`.
  - Load result = `bus_rdata` shifted right by 8·`addr[2:0]`, masked to the access size, upper bits zero. Sign extension is done in EX.
- BUS: hold `bus_req`, `bus_we`, `bus_addr`, `bus_wdata` and `bus_bsel` stable until `bus_ack`. Then:
  - `bus_err`=1: pulse the matching `*_acc_fault` next cycle, then go to DRAIN.
  - Uncacheable: next cycle pulse `uncache_data_ready` with `uncache_data` valid (loads). Then go to DRAIN.
  - Cacheable: go to RDY.
- RDY: pulse `cache_ready_ex`, then go to DATA.
- DATA: `data_read` is valid. Go to DRAIN.
- Stores complete through the same ready pulses; they carry no data.
- DRAIN: stay until `read`=`write`=0, then go to IDLE. A request held high across a completion is never re-issued.
- `data_read` and `uncache_data` hold their last value until the next load of the same class overwrites them.

## Timing
- Reset values:
  - All outputs 0.
  - `data_read` and `uncache_data` = 0.
  - State = IDLE.
- Reset mid-transaction: `bus_req` drops in the reset cycle and a late `bus_ack` is ignored. The bus slave must tolerate an abandoned request.
- Latency, with the request seen in cycle 0 and `bus_ack` in cycle k:
  - `bus_req` rises in cycle 2.
  - Cacheable: `cache_ready_ex` in cycle k+1, `data_read` valid in cycle k+2.
  - Uncacheable: `uncache_data_ready` in cycle k+1.
  - Bus error: fault pulse in cycle k+1.
- Illegal access: fault pulse in cycle 2; `bus_req` is never asserted.
- `bus_ack` in the first `bus_req` cycle is legal. Minimum cacheable load = 4 cycles to data.
- Ready and fault pulses are mutually exclusive and last exactly 1 cycle.
- Input changes outside IDLE are ignored.

## Configuration
- `BIU_UNCACHE_REGION_EN`:
  - Defined: the `UNC_BASE`/`UNC_MASK` decode is active. Matching addresses use the uncache path.
  - Undefined: every access is cacheable, and `uncache_data_ready`/`uncache_data` are tied 0.

## Structure
- Package `biu_pkg` holds:
  - the state enum;
  - size encoding constants `SZ_B`, `SZ_H`, `SZ_W`, `SZ_D`;
  - a size-to-byte-mask function.
- Sub-module `biu_lane_align` is combinational. It computes `bus_bsel`, `bus_wdata`, the load right-shift/mask, and the misaligned/illegal-size flag.
- FSM and registers live in `ex_biu_port`.

## Test plan
- Cacheable 8B load at 0x80, with `bus_ack` 3 cycles after `bus_req`: `bus_bsel`=FF, `cache_ready_ex` 1 cycle, `data_read` = `bus_rdata` the next cycle.
- 1B store of 0xA5 at 0x83: `bus_addr`=0x80, `bus_bsel`=08, `bus_wdata[31:24]`=A5, `cache_ready_ex` pulse, no fault.
- 4B load at 0x102: `load_acc_fault` in cycle 2, `bus_req` never rises. With `size_biu`=0011, the same result.
- Uncacheable 2B load at 0x1000_0006 with `bus_rdata`=0x1234_0000_0000_0000 (macro on): `uncache_data_ready` pulse with `uncache_data`=0x1234. With the macro off, it completes through the cacheable path.
- Store answered with `bus_err`=1: `store_acc_fault` pulse, no ready pulse. `write` held high → DRAIN and no second `bus_req` until `write` falls.
- `rst`=0 while in BUS: `bus_req`=0 next edge, outputs 0, a subsequent `bus_ack` produces no pulse.
